// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch front end.
package core_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        ERR
    } fetch_state_e;

    // Bytes per instruction word; the PC advances by this amount.
    localparam int unsigned INSTR_BYTES = 4;

    // addi x0, x0, 0 -- what decode should treat instr_o as while it is not valid.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for a memory response and reports when the
// count, including the current cycle, has reached the limit.
module fetch_timeout_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] count_q;

    // Cycle counter: cleared on grant, saturates so it never wraps back under the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= 8'd0;
        end else if (en_i && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    // The current waiting cycle is number count_q+1; expiry means that cycle hits the limit.
    assign expired_o = en_i && (({1'b0, count_q} + 9'd1) >= {1'b0, limit_i});

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/gnt/rvalid
// handshake, and presents one registered instruction at a time to decode.
//
// Handshakes:
//   imem: imem_req_o stays high until imem_gnt_i; imem_addr_o is sampled on the
//         grant cycle; exactly one imem_rvalid_i follows each grant, in order.
//   decode: instr_o/pc_o transfer on a cycle where instr_valid_o && instr_ready_i;
//         while instr_valid_o is high and not consumed, instr_o/pc_o stay stable.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o,
    output logic         instr_valid_o,
    input  logic         instr_ready_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         fetch_err_o,
    output fetch_state_e state_dbg_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         ctr_clr;
    logic         ctr_en;
    logic         expired;

    // A grant starts a new wait window; the window runs while a response is owed.
    assign ctr_clr = (state_q == REQ) && imem_gnt_i;
    assign ctr_en  = (state_q == WAIT) || (state_q == DRAIN);

    fetch_timeout_ctr u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (ctr_clr),
        .en_i      (ctr_en),
        .limit_i   (8'(TIMEOUT_CYCLES)),
        .expired_o (expired)
    );

    assign imem_addr_o = pc_q;
    assign state_dbg_o = state_q;

    // Fetch FSM with registered outputs; imem_req_o is high exactly while in REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            imem_req_o    <= 1'b0;
            instr_o       <= 32'd0;
            pc_o          <= 32'd0;
            instr_valid_o <= 1'b0;
            fetch_err_o   <= 1'b0;
        end else if (redirect_i && (state_q != ERR)) begin
            pc_q          <= redirect_pc_i;
            instr_valid_o <= 1'b0;
            if (!is_aligned(redirect_pc_i)) begin
                fetch_err_o <= 1'b1;
                imem_req_o  <= 1'b0;
                state_q     <= ERR;
            end else begin
                case (state_q)
                    REQ: begin
                        // A grant this cycle took the old address: its response must be dropped.
                        if (imem_gnt_i) begin
                            imem_req_o <= 1'b0;
                            state_q    <= DRAIN;
                        end else begin
                            imem_req_o <= 1'b1;
                            state_q    <= REQ;
                        end
                    end
                    WAIT, DRAIN: begin
                        // A response arriving now is the squashed one; otherwise wait it out.
                        if (imem_rvalid_i) begin
                            imem_req_o <= 1'b1;
                            state_q    <= REQ;
                        end else begin
                            imem_req_o <= 1'b0;
                            state_q    <= DRAIN;
                        end
                    end
                    default: begin
                        imem_req_o <= 1'b1;
                        state_q    <= REQ;
                    end
                endcase
            end
        end else begin
            case (state_q)
                IDLE: begin
                    imem_req_o <= 1'b1;
                    state_q    <= REQ;
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        imem_req_o <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        instr_o       <= imem_rdata_i;
                        pc_o          <= pc_q;
                        instr_valid_o <= 1'b1;
                        pc_q          <= pc_q + 32'(INSTR_BYTES);
                        state_q       <= HOLD;
                    end else if (expired) begin
                        fetch_err_o <= 1'b1;
                        state_q     <= ERR;
                    end
                end
                HOLD: begin
                    if (instr_ready_i) begin
                        instr_valid_o <= 1'b0;
                        imem_req_o    <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid_i) begin
                        imem_req_o <= 1'b1;
                        state_q    <= REQ;
                    end else if (expired) begin
                        fetch_err_o <= 1'b1;
                        state_q     <= ERR;
                    end
                end
                default: begin
                    // ERR: frozen until reset.
                    imem_req_o    <= 1'b0;
                    instr_valid_o <= 1'b0;
                    fetch_err_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written timeout and
// reset-PC sequences, then randomized traffic against a transaction-level model.
module tb_fetch_sequencer;
    import core_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0, TIMEOUT_CYCLES = 16)
    logic         rst, gnt, rvalid, ready, redir;
    logic [31:0]  rdata, rpc;
    logic         req, valid, err;
    logic [31:0]  addr, instr, pc;
    fetch_state_e st;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_o(instr), .pc_o(pc), .instr_valid_o(valid), .instr_ready_i(ready),
        .redirect_i(redir), .redirect_pc_i(rpc), .fetch_err_o(err), .state_dbg_o(st)
    );

    // Second DUT exercising the PC wrap (RESET_PC = FFFF_FFFC)
    logic         b_rst, b_gnt, b_rvalid, b_ready, b_redir;
    logic [31:0]  b_rdata, b_rpc;
    logic         b_req, b_valid, b_err;
    logic [31:0]  b_addr, b_instr, b_pc;
    fetch_state_e b_st;

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_wrap (
        .clk_i(clk), .rst_i(b_rst), .imem_req_o(b_req), .imem_addr_o(b_addr),
        .imem_gnt_i(b_gnt), .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
        .instr_o(b_instr), .pc_o(b_pc), .instr_valid_o(b_valid), .instr_ready_i(b_ready),
        .redirect_i(b_redir), .redirect_pc_i(b_rpc), .fetch_err_o(b_err), .state_dbg_o(b_st)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr, input logic [31:0] rp);
        rst = r; gnt = g; rvalid = rv; rdata = rd; ready = rdy; redir = rdr; rpc = rp;
    endtask

    task automatic b_drive(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                           input logic rdy);
        b_rst = r; b_gnt = g; b_rvalid = rv; b_rdata = rd; b_ready = rdy;
        b_redir = 1'b0; b_rpc = 32'd0;
    endtask

    // Memory contents used by the random test: any fixed address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, gnt, rvalid;
        logic [31:0] rdata;
        logic        ready, redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
        logic        e_err;
    } vec_t;

    localparam int NV = 22;
    vec_t tv[NV];

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h00A0_0113;
    localparam logic [31:0] I2 = 32'h1234_5678;

    initial begin
        int          hs;
        int          cyc;
        logic [31:0] exp_pc;
        logic [31:0] pend_addr[$];
        int          pend_due[$];

        drive(1'b1, 0, 0, 0, 0, 0, 0);
        b_drive(1'b1, 0, 0, 0, 0);

        //         rst  gnt rv  rdata          rdy rdr rpc            req addr          v  instr  pc             err
        tv[0]  = '{1'b1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 32'h0, 32'h0,        0};
        tv[1]  = '{1'b0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,        0, 32'h0, 32'h0,        0};
        tv[2]  = '{1'b0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 32'h0, 32'h0,        0};
        tv[3]  = '{1'b0, 0, 1, I0,             0, 0, 32'h0,          0, 32'h4,        1, I0,    32'h0,        0};
        tv[4]  = '{1'b0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,        0, I0,    32'h0,        0};
        tv[5]  = '{1'b0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h4,        0, I0,    32'h0,        0};
        tv[6]  = '{1'b0, 0, 1, I1,             0, 0, 32'h0,          0, 32'h8,        1, I1,    32'h4,        0};
        for (int i = 7; i <= 11; i++)
            tv[i] = '{1'b0, 0, 0, 32'h0,       0, 0, 32'h0,          0, 32'h8,        1, I1,    32'h4,        0};
        tv[12] = '{1'b0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,        0, I1,    32'h4,        0};
        tv[13] = '{1'b0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h8,        0, I1,    32'h4,        0};
        tv[14] = '{1'b0, 0, 0, 32'h0,          0, 1, 32'h100,        0, 32'h100,      0, I1,    32'h4,        0};
        tv[15] = '{1'b0, 0, 1, 32'hDEADBEEF,   0, 0, 32'h0,          1, 32'h100,      0, I1,    32'h4,        0};
        tv[16] = '{1'b0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h100,      0, I1,    32'h4,        0};
        tv[17] = '{1'b0, 0, 1, I2,             0, 0, 32'h0,          0, 32'h104,      1, I2,    32'h100,      0};
        tv[18] = '{1'b0, 0, 0, 32'h0,          1, 1, 32'h102,        0, 32'h102,      0, I2,    32'h100,      1};
        tv[19] = '{1'b0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h102,      0, I2,    32'h100,      1};
        tv[20] = '{1'b0, 0, 0, 32'h0,          0, 1, 32'h200,        0, 32'h102,      0, I2,    32'h100,      1};
        tv[21] = '{1'b1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 32'h0, 32'h0,        0};

        // Directed table: drive row inputs for one cycle, compare after the edge.
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rst, tv[i].gnt, tv[i].rvalid, tv[i].rdata, tv[i].ready, tv[i].redir, tv[i].rpc);
            step();
            check($sformatf("vec%0d_req", i),   32'(req),   32'(tv[i].e_req));
            check($sformatf("vec%0d_addr", i),  addr,       tv[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(tv[i].e_valid));
            check($sformatf("vec%0d_instr", i), instr,      tv[i].e_instr);
            check($sformatf("vec%0d_pc", i),    pc,         tv[i].e_pc);
            check($sformatf("vec%0d_err", i),   32'(err),   32'(tv[i].e_err));
        end

        // Timeout: grant, then no response for 16 waiting cycles.
        drive(0, 0, 0, 0, 0, 0, 0); step();           // IDLE -> REQ
        drive(0, 1, 0, 0, 0, 0, 0); step();           // grant -> WAIT
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) step();
        check("to_err_before_limit", 32'(err), 32'd0);
        step();
        check("to_err_at_limit", 32'(err), 32'd1);
        check("to_req_in_err", 32'(req), 32'd0);
        check("to_valid_in_err", 32'(valid), 32'd0);

        // Same, but the response lands on the 16th waiting cycle.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        check("to2_err_cleared", 32'(err), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) step();
        drive(0, 0, 1, 32'hCAFE_0013, 0, 0, 0); step();
        check("to2_err", 32'(err), 32'd0);
        check("to2_valid", 32'(valid), 32'd1);
        check("to2_instr", instr, 32'hCAFE_0013);
        check("to2_pc", pc, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0); step();
        check("to2_err_after", 32'(err), 32'd0);

        // PC wrap from FFFF_FFFC and reset during WAIT on the second DUT.
        b_drive(1, 0, 0, 0, 0); step();
        check("wr_rst_addr", b_addr, 32'hFFFF_FFFC);
        check("wr_rst_req", 32'(b_req), 32'd0);
        b_drive(0, 0, 0, 0, 0); step();
        check("wr_req", 32'(b_req), 32'd1);
        check("wr_req_addr", b_addr, 32'hFFFF_FFFC);
        b_drive(0, 1, 0, 0, 0); step();
        b_drive(0, 0, 1, 32'h0000_0013, 0); step();
        check("wr_valid", 32'(b_valid), 32'd1);
        check("wr_pc", b_pc, 32'hFFFF_FFFC);
        check("wr_next_addr", b_addr, 32'h0);
        b_drive(0, 0, 0, 0, 1); step();
        check("wr_req2", 32'(b_req), 32'd1);
        check("wr_req2_addr", b_addr, 32'h0);
        b_drive(0, 1, 0, 0, 0); step();                // now in WAIT
        b_drive(1, 0, 0, 0, 0); step();                // reset mid-fetch
        check("wr_rst2_addr", b_addr, 32'hFFFF_FFFC);
        check("wr_rst2_valid", 32'(b_valid), 32'd0);
        b_drive(0, 0, 1, 32'h0BAD_0BAD, 0); step();    // stale response after reset
        check("wr_stale_valid", 32'(b_valid), 32'd0);
        check("wr_stale_req", 32'(b_req), 32'd1);
        check("wr_stale_addr", b_addr, 32'hFFFF_FFFC);
        check("wr_stale_instr", b_instr, 32'h0);
        b_drive(0, 0, 0, 0, 0);

        // Random traffic: in-order memory with random grant and response delays,
        // random backpressure and aligned redirects. Delivered instructions must
        // follow the program order implied by sequential fetch and redirects.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        exp_pc = 32'h0;
        hs = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; redir = 1'b0; rpc = 32'h0;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                rvalid = 1'b1;
                rdata  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (req && ($urandom_range(0, 2) != 0)) begin
                gnt = 1'b1;
                check("rand_gnt_align", 32'(addr[1:0]), 32'd0);
                pend_addr.push_back(addr);
                pend_due.push_back(cyc + 1 + int'($urandom_range(0, 5)));
            end
            ready = ($urandom_range(0, 3) != 0);
            if (valid && ready) begin
                exp_q.push_back(mem_word(exp_pc));
                check("rand_pc", pc, exp_pc);
                check("rand_instr", instr, exp_q.pop_front());
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            if ($urandom_range(0, 15) == 0) begin
                redir  = 1'b1;
                rpc    = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
                exp_pc = rpc;
            end
            check("rand_err", 32'(err), 32'd0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rand_progress", 32'(hs >= 100), 32'd1);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
